// File: rtl/fa_bist_checker.sv
// Response-side BIST checker for a full-adder under test.
// Accepts {A,B,C} patterns with the adder's Sum/Carry, compares them against the
// ideal full-adder function, counts mismatches (saturating), captures the first
// failing pattern and flags out-of-order patterns. Reports done/pass per run.
// Optional: define FA_BIST_CHECKER_MISR_EN to add an 8-bit MISR response
// signature output (signature_o).
module fa_bist_checker #(
  parameter int unsigned NUM_PATTERNS = 8,
  parameter int unsigned ERR_W        = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             pat_valid_i,
  input  logic [2:0]       pat_i,
  input  logic             sum_i,
  input  logic             carry_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic             mismatch_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic [2:0]       first_fail_o,
  output logic             first_fail_vld_o,
  output logic             seq_err_o
`ifdef FA_BIST_CHECKER_MISR_EN
  ,
  output logic [7:0]       signature_o
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [2:0] LastIdx = 3'(NUM_PATTERNS - 1);

  state_e           state_q;
  logic [2:0]       idx_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic             mismatch_q;
  logic [ERR_W-1:0] err_cnt_q;
  logic [2:0]       first_fail_q;
  logic             first_fail_vld_q;
  logic             seq_err_q;

  logic             exp_sum;
  logic             exp_carry;
  logic             fail;
  logic             seq_bad;
  logic             last_pat;
  logic [ERR_W-1:0] err_cnt_inc;

  // Ideal full-adder reference and per-acceptance decisions.
  always_comb begin
    exp_sum     = ^pat_i;
    exp_carry   = (pat_i[2] & pat_i[1]) | (pat_i[2] & pat_i[0]) | (pat_i[1] & pat_i[0]);
    fail        = (sum_i != exp_sum) || (carry_i != exp_carry);
    seq_bad     = (pat_i != idx_q);
    last_pat    = (idx_q == LastIdx);
    err_cnt_inc = (&err_cnt_q) ? err_cnt_q : err_cnt_q + ERR_W'(1);
  end

`ifdef FA_BIST_CHECKER_MISR_EN
  logic [7:0] sig_q;

  // MISR: reseeded on start, advanced only on accepted patterns, frozen otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= 8'hFF;
    end else if (state_q != StRun && start_i) begin
      sig_q <= 8'hFF;
    end else if (state_q == StRun && pat_valid_i) begin
      sig_q <= {sig_q[6:0], sig_q[7] ^ sig_q[5] ^ sig_q[4] ^ sig_q[3]} ^
               {6'b0, sum_i, carry_i};
    end
  end

  assign signature_o = sig_q;
`endif

  // Run-control FSM with registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      idx_q            <= 3'd0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      mismatch_q       <= 1'b0;
      err_cnt_q        <= '0;
      first_fail_q     <= 3'd0;
      first_fail_vld_q <= 1'b0;
      seq_err_q        <= 1'b0;
    end else begin
      mismatch_q <= 1'b0;
      case (state_q)
        StIdle, StDone: begin
          // pat_valid is ignored here, even alongside start.
          if (start_i) begin
            state_q          <= StRun;
            busy_q           <= 1'b1;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            err_cnt_q        <= '0;
            first_fail_vld_q <= 1'b0;
            seq_err_q        <= 1'b0;
            idx_q            <= 3'd0;
          end
        end
        StRun: begin
          // start is ignored while running; gaps (pat_valid=0) have no effect.
          if (pat_valid_i) begin
            idx_q <= idx_q + 3'd1;
            if (fail) begin
              mismatch_q <= 1'b1;
              err_cnt_q  <= err_cnt_inc;
              if (!first_fail_vld_q) begin
                first_fail_q     <= pat_i;
                first_fail_vld_q <= 1'b1;
              end
            end
            if (seq_bad) begin
              seq_err_q <= 1'b1;
            end
            if (last_pat) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              // Fold in the last pattern's own result.
              pass_q  <= !fail && (err_cnt_q == '0) && !seq_err_q && !seq_bad;
            end
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign pass_o           = pass_q;
  assign mismatch_o       = mismatch_q;
  assign err_cnt_o        = err_cnt_q;
  assign first_fail_o     = first_fail_q;
  assign first_fail_vld_o = first_fail_vld_q;
  assign seq_err_o        = seq_err_q;

endmodule

// File: tb/tb_fa_bist_checker.sv
// Directed bench for fa_bist_checker: ideal, carry stuck-at-0, inverted sum
// (with a second ERR_W=2 instance), out-of-order, gaps plus mid-run reset.
module tb_fa_bist_checker;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       pat_valid;
  logic [2:0] pat;
  logic       sum;
  logic       carry;

  logic       busy, done, pass, mm, ffv, seq;
  logic [3:0] err;
  logic [2:0] ff;
  logic       busy2, done2, pass2, mm2, ffv2, seq2;
  logic [1:0] err2;
  logic [2:0] ff2;
`ifdef FA_BIST_CHECKER_MISR_EN
  logic [7:0] sig;
  logic [7:0] sig2;
  logic [7:0] sig_ideal;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int mode  = 0;  // 0 ideal, 1 carry stuck-at-0, 2 sum inverted

  // Hand-derived expectations for the carry stuck-at-0 run (pats 0..7).
  int exp_mm_c[8]  = '{0, 0, 0, 1, 0, 1, 1, 1};
  int exp_cnt_c[8] = '{0, 0, 0, 1, 1, 2, 3, 4};

  fa_bist_checker #(.NUM_PATTERNS(8), .ERR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .pat_valid_i(pat_valid), .pat_i(pat),
    .sum_i(sum), .carry_i(carry), .busy_o(busy), .done_o(done), .pass_o(pass),
    .mismatch_o(mm), .err_cnt_o(err), .first_fail_o(ff), .first_fail_vld_o(ffv),
    .seq_err_o(seq)
`ifdef FA_BIST_CHECKER_MISR_EN
    , .signature_o(sig)
`endif
  );

  fa_bist_checker #(.NUM_PATTERNS(8), .ERR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .pat_valid_i(pat_valid), .pat_i(pat),
    .sum_i(sum), .carry_i(carry), .busy_o(busy2), .done_o(done2), .pass_o(pass2),
    .mismatch_o(mm2), .err_cnt_o(err2), .first_fail_o(ff2), .first_fail_vld_o(ffv2),
    .seq_err_o(seq2)
`ifdef FA_BIST_CHECKER_MISR_EN
    , .signature_o(sig2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic fa_s(input logic [2:0] p);
    return p[2] ^ p[1] ^ p[0];
  endfunction

  function automatic logic fa_c(input logic [2:0] p);
    return (p[2] & p[1]) | (p[2] & p[0]) | (p[1] & p[0]);
  endfunction

  function automatic logic [7:0] misr(input logic [7:0] s, input logic su, input logic ca);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]} ^ {6'b0, su, ca};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a pattern with the adder-under-test response for the current fault mode.
  task automatic drive(input logic [2:0] p, input logic v);
    pat       = p;
    pat_valid = v;
    sum       = fa_s(p) ^ (mode == 2);
    carry     = (mode == 1) ? 1'b0 : fa_c(p);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    drive(3'd5, 1'b1);  // must be ignored alongside start
    tick();
    start = 1'b0;
    drive(3'd0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    drive(3'd0, 1'b0);
`ifdef FA_BIST_CHECKER_MISR_EN
    sig_ideal = 8'hFF;
    for (int p = 0; p < 8; p++) sig_ideal = misr(sig_ideal, fa_s(3'(p)), fa_c(3'(p)));
`endif
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err, 0);
    chk("rst_ffv", ffv, 0);
    chk("rst_ff", ff, 0);
    chk("rst_seq", seq, 0);
    chk("rst_mm", mm, 0);
`ifdef FA_BIST_CHECKER_MISR_EN
    chk("rst_sig", sig, 8'hFF);
`endif
    tick();
    tick();
    rst_n = 1'b1;
    // pat_valid in IDLE without start is ignored
    drive(3'd3, 1'b1);
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_seq", seq, 0);

    // Ideal run 0..7
    mode = 0;
    pulse_start();
    chk("t1_busy", busy, 1);
    chk("t1_seq_start", seq, 0);
    for (int p = 0; p < 8; p++) begin
      drive(3'(p), 1'b1);
      tick();
      chk($sformatf("t1_mm%0d", p), mm, 0);
      chk($sformatf("t1_done%0d", p), done, (p == 7) ? 1 : 0);
    end
    drive(3'd0, 1'b0);
    chk("t1_busy_end", busy, 0);
    chk("t1_pass", pass, 1);
    chk("t1_err", err, 0);
    chk("t1_seq", seq, 0);
    chk("t1_ffv", ffv, 0);
`ifdef FA_BIST_CHECKER_MISR_EN
    chk("t1_sig", sig, sig_ideal);
`endif
    // DONE holds; an out-of-order pattern here is ignored
    drive(3'd2, 1'b1);
    tick();
    chk("t1_hold_done", done, 1);
    chk("t1_hold_pass", pass, 1);
    chk("t1_hold_seq", seq, 0);
`ifdef FA_BIST_CHECKER_MISR_EN
    chk("t1_hold_sig", sig, sig_ideal);
`endif

    // Carry stuck-at-0
    mode = 1;
    pulse_start();
    chk("t2_done_clr", done, 0);
    chk("t2_pass_clr", pass, 0);
    chk("t2_busy", busy, 1);
    for (int p = 0; p < 8; p++) begin
      drive(3'(p), 1'b1);
      tick();
      chk($sformatf("t2_mm%0d", p), mm, exp_mm_c[p]);
      chk($sformatf("t2_err%0d", p), err, exp_cnt_c[p]);
    end
    drive(3'd0, 1'b0);
    tick();
    chk("t2_mm_idle", mm, 0);
    chk("t2_done", done, 1);
    chk("t2_err", err, 4);
    chk("t2_ff", ff, 3'b011);
    chk("t2_ffv", ffv, 1);
    chk("t2_pass", pass, 0);
`ifdef FA_BIST_CHECKER_MISR_EN
    n_cmp++;
    assert (sig !== sig_ideal) else begin
      n_bad++;
      $error("FAIL t2_sig_differs: observed 0x%0h expected not 0x%0h", sig, sig_ideal);
    end
`endif

    // Sum inverted: every pattern fails; ERR_W=2 instance saturates at 3
    mode = 2;
    pulse_start();
    chk("t3_ffv_clr", ffv, 0);
    chk("t3_err_clr", err, 0);
    for (int p = 0; p < 8; p++) begin
      drive(3'(p), 1'b1);
      tick();
      chk($sformatf("t3_mm%0d", p), mm, 1);
      chk($sformatf("t3_err2_%0d", p), err2, (p < 3) ? p + 1 : 3);
    end
    drive(3'd0, 1'b0);
    chk("t3_err", err, 8);
    chk("t3_ff", ff, 0);
    chk("t3_pass", pass, 0);
    chk("t3_done2", done2, 1);
    chk("t3_pass2", pass2, 0);
    chk("t3_err2", err2, 3);

    // Out-of-order: 0,1,3,2,4..7
    mode = 0;
    pulse_start();
    drive(3'd0, 1'b1); tick();
    drive(3'd1, 1'b1); tick();
    chk("t4_seq_early", seq, 0);
    drive(3'd3, 1'b1); tick();
    chk("t4_seq_set", seq, 1);
    chk("t4_mm3", mm, 0);
    drive(3'd2, 1'b1); tick();
    for (int p = 4; p < 8; p++) begin
      drive(3'(p), 1'b1);
      tick();
    end
    drive(3'd0, 1'b0);
    chk("t4_done", done, 1);
    chk("t4_seq", seq, 1);
    chk("t4_err", err, 0);
    chk("t4_ffv", ffv, 0);
    chk("t4_pass", pass, 0);

    // Gaps, start during RUN, reset after pat 4
    pulse_start();
    drive(3'd0, 1'b1); tick();
    drive(3'd0, 1'b0); tick();
    drive(3'd1, 1'b1); tick();
    start = 1'b1;
    drive(3'd0, 1'b0); tick();  // start ignored in RUN
    start = 1'b0;
    drive(3'd2, 1'b1); tick();
    drive(3'd3, 1'b1); tick();
    drive(3'd0, 1'b0); tick();
    drive(3'd4, 1'b1); tick();
    drive(3'd0, 1'b0);
    chk("t5_busy_gap", busy, 1);
    chk("t5_seq_gap", seq, 0);
    chk("t5_done_gap", done, 0);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", done, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t5_no_done", done, 0);
    pulse_start();
    for (int p = 0; p < 8; p++) begin
      drive(3'(p), 1'b1);
      tick();
      if (p == 5) begin
        drive(3'd0, 1'b0);
        tick();
      end
    end
    drive(3'd0, 1'b0);
    chk("t5_done", done, 1);
    chk("t5_pass", pass, 1);
    chk("t5_seq", seq, 0);
    chk("t5_err", err, 0);
`ifdef FA_BIST_CHECKER_MISR_EN
    chk("t5_sig", sig, sig_ideal);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
